// File: rtl/fetch_pkg.sv
// fetch_pkg: halfword type, instruction width and sizing helpers shared by
// the fetch queue, its bus interface and the halfword FIFO.
// Optional feature macro used by the design: FETCH_QUEUE_COMPRESSED_EN.
package fetch_pkg;

   typedef logic [15:0] halfword_t;

   localparam int ILEN = 32;

   function automatic logic is_compressed(input halfword_t hw);
      return hw[1:0] != 2'b11;
   endfunction

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Depth is a power of two, so pointers wrap naturally.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-port and execution-side signals of the fetch queue.
// master = fetch_queue, slave = memory/execution environment.
interface fetch_queue_if
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] instr_addr;
   logic            mem_req;
   logic [ILEN-1:0] instr_in;
   logic            je;
   logic [XLEN-1:0] ja;
   logic            stall;
   logic            instr_valid;
   logic [ILEN-1:0] instr_out;
   logic [XLEN-1:0] curr_pc;
   logic [XLEN-1:0] inc_pc;

   modport master (
      output instr_addr, mem_req, instr_valid, instr_out, curr_pc, inc_pc,
      input  instr_in, je, ja, stall
   );

   modport slave (
      input  instr_addr, mem_req, instr_valid, instr_out, curr_pc, inc_pc,
      output instr_in, je, ja, stall
   );
endinterface

// File: rtl/hw_fifo.sv
// hw_fifo: halfword FIFO with 0/1/2-wide push and pop per cycle and a
// single-cycle flush. Full/empty are told apart by the occupancy count.
module hw_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_flush,
   input  logic [1:0]                    i_push_n,
   input  halfword_t                     i_push_d0,
   input  halfword_t                     i_push_d1,
   input  logic [1:0]                    i_pop_n,
   output halfword_t                     o_head0,
   output halfword_t                     o_head1,
   output logic [cnt_width(DEPTH)-1:0]   o_count
);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = ptr_width(DEPTH);

   halfword_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_count;

   // pointer and occupancy update; flush empties the queue in one cycle
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= r_wr + PTR_W'(i_push_n);
         r_rd    <= r_rd + PTR_W'(i_pop_n);
         r_count <= r_count + CNT_W'(i_push_n) - CNT_W'(i_pop_n);
      end
   end

   // storage write, low halfword first; contents need no reset
   always_ff @(posedge clk) begin
      if (!(rst || i_flush)) begin
         if (i_push_n != 2'd0) r_mem[r_wr] <= i_push_d0;
         if (i_push_n == 2'd2) r_mem[r_wr + PTR_W'(1)] <= i_push_d1;
      end
   end

   assign o_head0 = r_mem[r_rd];
   assign o_head1 = r_mem[r_rd + PTR_W'(1)];
   assign o_count = r_count;

   // the issue throttle upstream must keep occupancy within 0..DEPTH
   a_no_overflow: assert property (@(posedge clk) disable iff (rst || i_flush)
      ((int'(r_count) + int'(i_push_n) - int'(i_pop_n)) <= int'(DEPTH)) &&
      (int'(i_pop_n) <= int'(r_count)));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: word-aligned instruction prefetch into a halfword FIFO, with
// realignment of compressed and straddling instructions and one-cycle redirect.
// FETCH_QUEUE_COMPRESSED_EN: when defined, 16-bit instructions and halfword
// jump targets are supported; otherwise every instruction is one 32-bit word.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.master bus
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [CNT_W-1:0] w_count;
   halfword_t        w_head0;
   halfword_t        w_head1;
   logic             w_comp;
   logic             w_valid;
   logic             w_mem_req;
   logic [1:0]       w_push_n;
   logic [1:0]       w_pop_n;
   halfword_t        w_push_d0;
   halfword_t        w_push_d1;
   logic [XLEN-1:0]  w_target_pc;
   logic [XLEN-1:0]  w_inc_pc;
   logic             w_unused_ja;

   logic             r_inflight;
   logic [XLEN-1:0]  r_fetch_addr;
   logic [XLEN-1:0]  r_pc;

   assign w_push_d1   = bus.instr_in[31:16];
   assign w_unused_ja = ^bus.ja[1:0];

`ifdef FETCH_QUEUE_COMPRESSED_EN
   logic r_skip_lo;

   // head is only meaningful when the queue holds something
   assign w_comp      = (w_count != '0) && is_compressed(w_head0);
   assign w_push_n    = (r_inflight && !bus.je) ? (r_skip_lo ? 2'd1 : 2'd2) : 2'd0;
   assign w_push_d0   = r_skip_lo ? bus.instr_in[31:16] : bus.instr_in[15:0];
   assign w_target_pc = {bus.ja[XLEN-1:1], 1'b0};

   // a jump into the upper halfword drops the low half of the first word back
   always_ff @(posedge clk) begin
      if (rst)               r_skip_lo <= RESET_PC[1];
      else if (bus.je)       r_skip_lo <= bus.ja[1];
      else if (r_inflight)   r_skip_lo <= 1'b0;
   end
`else
   assign w_comp      = 1'b0;
   assign w_push_n    = (r_inflight && !bus.je) ? 2'd2 : 2'd0;
   assign w_push_d0   = bus.instr_in[15:0];
   assign w_target_pc = {bus.ja[XLEN-1:2], 2'b00};
`endif

   assign w_valid  = (w_comp ? (w_count >= CNT_W'(1)) : (w_count >= CNT_W'(2))) && !bus.je;
   assign w_pop_n  = (w_valid && !bus.stall) ? (w_comp ? 2'd1 : 2'd2) : 2'd0;
   assign w_inc_pc = r_pc + (w_comp ? XLEN'(2) : XLEN'(4));

   // room must remain for the queue, the response in flight and the new one
   assign w_mem_req = !rst && !bus.je &&
                      ((int'(w_count) + (r_inflight ? 2 : 0) + 2) <= int'(DEPTH));

   hw_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (bus.je),
      .i_push_n  (w_push_n),
      .i_push_d0 (w_push_d0),
      .i_push_d1 (w_push_d1),
      .i_pop_n   (w_pop_n),
      .o_head0   (w_head0),
      .o_head1   (w_head1),
      .o_count   (w_count)
   );

   // a request issued this cycle returns next cycle; a jump squashes it
   always_ff @(posedge clk) begin
      if (rst) r_inflight <= 1'b0;
      else     r_inflight <= w_mem_req;
   end

   // fetch address: redirect to the target word, else advance per issue
   always_ff @(posedge clk) begin
      if (rst)            r_fetch_addr <= {RESET_PC[XLEN-1:2], 2'b00};
      else if (bus.je)    r_fetch_addr <= {bus.ja[XLEN-1:2], 2'b00};
      else if (w_mem_req) r_fetch_addr <= r_fetch_addr + XLEN'(4);
   end

   // program counter of the instruction at the head of the queue
   always_ff @(posedge clk) begin
      if (rst)                   r_pc <= RESET_PC;
      else if (bus.je)           r_pc <= w_target_pc;
      else if (w_pop_n != 2'd0)  r_pc <= w_inc_pc;
   end

   assign bus.instr_addr  = r_fetch_addr;
   assign bus.mem_req     = w_mem_req;
   assign bus.instr_valid = w_valid;
   assign bus.instr_out   = !w_valid ? '0 :
                            (w_comp ? {16'h0000, w_head0} : {w_head1, w_head0});
   assign bus.curr_pc     = r_pc;
   assign bus.inc_pc      = w_inc_pc;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue. Expectations
// adapt to whether FETCH_QUEUE_COMPRESSED_EN is defined.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 8;

`ifdef FETCH_QUEUE_COMPRESSED_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(XLEN)) bus ();

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory model: word requested in one cycle is presented the next
   logic [31:0]     mem [256];
   logic [XLEN-1:0] prev_addr = '0;
   always @(posedge clk) prev_addr <= bus.instr_addr;
   assign bus.instr_in = mem[prev_addr[9:2]];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        stall;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] inc;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t vec [9];

   function automatic logic [31:0] wd(input int i);
      return 32'h0000_0013 | (32'(i) << 20);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] inc);
      chk({tag, " valid"}, 32'(bus.instr_valid), 32'(v));
      if (v) begin
         chk({tag, " instr"}, bus.instr_out, instr);
         chk({tag, " pc"}, bus.curr_pc, pc);
         chk({tag, " inc"}, bus.inc_pc, inc);
      end
   endtask

   task automatic expect_bus(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, " req"}, 32'(bus.mem_req), 32'(req));
      if (req) chk({tag, " addr"}, bus.instr_addr, addr);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = wd(i);
   endtask

   // leaves the bench at the start of the first cycle with rst low (c0)
   task automatic do_reset(input logic stall_v);
      rst       = 1'b1;
      bus.je    = 1'b0;
      bus.ja    = '0;
      bus.stall = stall_v;
      adv();
      adv();
      @(negedge clk);
      chk("rst valid", 32'(bus.instr_valid), 32'd0);
      chk("rst req",   32'(bus.mem_req),     32'd0);
      chk("rst addr",  bus.instr_addr,       32'h0);
      chk("rst pc",    bus.curr_pc,          32'h0);
      chk("rst inc",   bus.inc_pc,           32'h4);
      chk("rst instr", bus.instr_out,        32'h0);
      adv();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // steady 32-bit stream, with one stall cycle at c6
      vec[0] = '{1'b0, 1'b0, 32'h0,  32'h00, 32'h04, 1'b1, 32'h00};
      vec[1] = '{1'b0, 1'b0, 32'h0,  32'h00, 32'h04, 1'b1, 32'h04};
      vec[2] = '{1'b0, 1'b1, wd(0),  32'h00, 32'h04, 1'b1, 32'h08};
      vec[3] = '{1'b0, 1'b1, wd(1),  32'h04, 32'h08, 1'b1, 32'h0C};
      vec[4] = '{1'b0, 1'b1, wd(2),  32'h08, 32'h0C, 1'b1, 32'h10};
      vec[5] = '{1'b0, 1'b1, wd(3),  32'h0C, 32'h10, 1'b1, 32'h14};
      vec[6] = '{1'b1, 1'b1, wd(4),  32'h10, 32'h14, 1'b1, 32'h18};
      vec[7] = '{1'b0, 1'b1, wd(4),  32'h10, 32'h14, 1'b1, 32'h1C};
      vec[8] = '{1'b0, 1'b1, wd(5),  32'h14, 32'h18, 1'b1, 32'h20};

      bus.je = 1'b0; bus.ja = '0; bus.stall = 1'b0;

      // reset and steady stream
      fill_mem();
      do_reset(1'b0);
      for (int i = 0; i < 9; i++) begin
         bus.stall = vec[i].stall;
         @(negedge clk);
         expect_out($sformatf("t1 c%0d", i), vec[i].v, vec[i].instr, vec[i].pc, vec[i].inc);
         expect_bus($sformatf("t1 c%0d", i), vec[i].req, vec[i].addr);
         adv();
      end
      bus.stall = 1'b0;

      // two compressed instructions in one word
      fill_mem();
      mem[0] = 32'h4501_4501;
      mem[1] = 32'h0000_0013;
      do_reset(1'b0);
      adv(); adv();
      @(negedge clk);
      expect_out("t2 c2", 1'b1, CEN ? 32'h0000_4501 : 32'h4501_4501, 32'h0, CEN ? 32'h2 : 32'h4);
      adv(); @(negedge clk);
      expect_out("t2 c3", 1'b1, CEN ? 32'h0000_4501 : 32'h0000_0013, CEN ? 32'h2 : 32'h4,
                 CEN ? 32'h4 : 32'h8);
      adv(); @(negedge clk);
      expect_out("t2 c4", 1'b1, CEN ? 32'h0000_0013 : wd(2), CEN ? 32'h4 : 32'h8,
                 CEN ? 32'h8 : 32'hC);

      // 32-bit instruction straddling two words
      fill_mem();
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h0000_0000;
      do_reset(1'b0);
      adv(); adv();
      @(negedge clk);
      expect_out("t3 c2", 1'b1, CEN ? 32'h0000_4501 : 32'h0013_4501, 32'h0, CEN ? 32'h2 : 32'h4);
      adv(); @(negedge clk);
      expect_out("t3 c3", 1'b1, CEN ? 32'h0000_0013 : 32'h0000_0000, CEN ? 32'h2 : 32'h4,
                 CEN ? 32'h6 : 32'h8);

      // long stall: issue throttles, PC frozen, nothing lost on release
      fill_mem();
      do_reset(1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("t4 req c%0d", c), 32'(bus.mem_req), (c < 4) ? 32'd1 : 32'd0);
         chk($sformatf("t4 valid c%0d", c), 32'(bus.instr_valid), (c >= 2) ? 32'd1 : 32'd0);
         chk($sformatf("t4 pc c%0d", c), bus.curr_pc, 32'h0);
         adv();
      end
      bus.stall = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         expect_out($sformatf("t4 rel%0d", k), 1'b1, wd(k), 32'(4 * k), 32'(4 * k + 4));
         chk($sformatf("t4 rel%0d req", k), 32'(bus.mem_req), (k != 0) ? 32'd1 : 32'd0);
         chk($sformatf("t4 rel%0d addr", k), bus.instr_addr,
             (k == 0) ? 32'h10 : 32'(32'h10 + 4 * (k - 1)));
         adv();
      end

      // jump to 0x102 with a fetch in flight, coinciding with push and pop
      fill_mem();
      mem[8'h40] = 32'h4501_0013;
      do_reset(1'b0);
      adv(); adv(); adv();
      bus.je = 1'b1;
      bus.ja = 32'h0000_0102;
      @(negedge clk);
      chk("t5 je valid", 32'(bus.instr_valid), 32'd0);
      chk("t5 je req",   32'(bus.mem_req),     32'd0);
      adv();
      bus.je = 1'b0;
      bus.ja = '0;
      @(negedge clk);
      expect_bus("t5 c4", 1'b1, 32'h100);
      chk("t5 c4 valid", 32'(bus.instr_valid), 32'd0);
      chk("t5 c4 pc", bus.curr_pc, CEN ? 32'h102 : 32'h100);
      adv(); @(negedge clk);
      expect_bus("t5 c5", 1'b1, 32'h104);
      chk("t5 c5 valid", 32'(bus.instr_valid), 32'd0);
      adv(); @(negedge clk);
      expect_out("t5 c6", 1'b1, CEN ? 32'h0000_4501 : 32'h4501_0013, CEN ? 32'h102 : 32'h100,
                 32'h104);
      adv(); @(negedge clk);
      expect_out("t5 c7", 1'b1, wd(8'h41), 32'h104, 32'h108);

      // reset asserted mid-stream for one cycle
      fill_mem();
      do_reset(1'b0);
      adv(); adv(); adv();
      rst = 1'b1;
      @(negedge clk);
      chk("t6 rst req", 32'(bus.mem_req), 32'd0);
      adv();
      rst = 1'b0;
      @(negedge clk);
      expect_bus("t6 c4", 1'b1, 32'h0);
      chk("t6 c4 valid", 32'(bus.instr_valid), 32'd0);
      chk("t6 c4 pc", bus.curr_pc, 32'h0);
      chk("t6 c4 inc", bus.inc_pc, 32'h4);
      adv(); @(negedge clk);
      expect_bus("t6 c5", 1'b1, 32'h4);
      chk("t6 c5 valid", 32'(bus.instr_valid), 32'd0);
      adv(); @(negedge clk);
      expect_out("t6 c6", 1'b1, wd(0), 32'h0, 32'h4);
      adv(); @(negedge clk);
      expect_out("t6 c7", 1'b1, wd(1), 32'h4, 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
